// File: rtl/lsq_core_if.sv
// Data-memory port of the load/store queue.
// master = LSQ side, slave = memory side.
interface lsq_core_if #(
  parameter int OPRAND_WIDTH = 32
);

  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_we;
  logic [1:0]              mem_req_size;
  logic [OPRAND_WIDTH-1:0] mem_req_addr;
  logic [OPRAND_WIDTH-1:0] mem_req_wdata;
  logic                    mem_resp_valid;
  logic [OPRAND_WIDTH-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid,
    output mem_req_we,
    output mem_req_size,
    output mem_req_addr,
    output mem_req_wdata,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_we,
    input  mem_req_size,
    input  mem_req_addr,
    input  mem_req_wdata,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_rdata
  );

endinterface

// File: rtl/lsq_core.sv
// Load/store queue: in-order allocate, address fill, commit,
// and in-order retirement to a single-request memory port.
module lsq_core #(
  parameter int LSQ_INDEX_WIDTH = 5,
  parameter int OPRAND_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ls_valid1,
  input  logic                       ls_valid2,
  input  logic [2:0]                 ls_type1,
  input  logic [2:0]                 ls_type2,
  output logic [LSQ_INDEX_WIDTH-1:0] ls_entry1,
  output logic [LSQ_INDEX_WIDTH-1:0] ls_entry2,
  output logic                       lsq_full,
  input  logic                       addr_valid,
  input  logic [LSQ_INDEX_WIDTH-1:0] addr_entry,
  input  logic [OPRAND_WIDTH-1:0]    addr,
  input  logic [OPRAND_WIDTH-1:0]    store_data,
  input  logic                       load_commit_valid,
  input  logic                       store_commit_valid,
  input  logic [LSQ_INDEX_WIDTH-1:0] load_commit_entry,
  input  logic [LSQ_INDEX_WIDTH-1:0] store_commit_entry,
  input  logic                       squash,
  output logic [OPRAND_WIDTH-1:0]    load_data,
  output logic                       load_data_valid,
  output logic [LSQ_INDEX_WIDTH-1:0] load_data_entry,
  output logic                       flush_valid,
  output logic [LSQ_INDEX_WIDTH-1:0] flush_entry,
  lsq_core_if.master                 mem
);

  localparam int IW    = LSQ_INDEX_WIDTH;
  localparam int OW    = OPRAND_WIDTH;
  localparam int DEPTH = 1 << IW;

  typedef logic [IW:0]   ptr_t;
  typedef logic [IW-1:0] idx_t;
  typedef logic [OW-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP
  } st_t;

  ptr_t head;
  ptr_t cmt_ptr;
  ptr_t tail;
  ptr_t count;
  ptr_t alloc_n;
  ptr_t cmt_n;
  ptr_t tail_n;
  ptr_t drop_n;
  ptr_t off;

  logic [2:0] ent_type [DEPTH];
  word_t      ent_addr [DEPTH];
  word_t      ent_data [DEPTH];

  logic [DEPTH-1:0] addr_rdy;
  logic [DEPTH-1:0] committed;
  logic [DEPTH-1:0] discard;

  logic alloc_ok;
  logic aw_mis;
  logic head_ready;
  logic retire;
  idx_t hidx;
  logic [2:0] aw_type;
  logic [2:0] h_type;

  st_t   state;
  logic  req_valid_q;
  logic  req_we_q;
  logic  [1:0] req_size_q;
  word_t req_addr_q;
  word_t req_wdata_q;

  assign count     = tail - head;
  assign lsq_full  = count >= ptr_t'(DEPTH - 1);
  assign ls_entry1 = tail[IW-1:0];
  assign ls_entry2 = tail[IW-1:0] + idx_t'(ls_valid1);
  assign alloc_ok  = !lsq_full && !squash;

  assign hidx    = head[IW-1:0];
  assign h_type  = ent_type[hidx];
  assign aw_type = ent_type[addr_entry];

  assign head_ready = (head != tail)
                    && committed[hidx]
                    && addr_rdy[hidx];

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_we    = req_we_q;
  assign mem.mem_req_size  = req_size_q;
  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_wdata = req_wdata_q;

  // Zero-extend a returned load to the access size.
  function automatic word_t zext(
    input logic [1:0] sz,
    input word_t      d
  );
    word_t r;
    unique case (1'b1)
      sz == 2'b00: r = OW'(d[7:0]);
      sz == 2'b01: r = OW'(d[15:0]);
      default:     r = d;
    endcase
    return r;
  endfunction

  // Alignment check of the incoming address against its entry size.
  always_comb begin
    aw_mis = 1'b0;
    unique case (1'b1)
      aw_type[1:0] == 2'b00: aw_mis = 1'b0;
      aw_type[1:0] == 2'b01: aw_mis = addr[0];
      default:               aw_mis = |addr[1:0];
    endcase
  end

  // Next-pointer arithmetic for allocate, commit and squash.
  always_comb begin
    alloc_n = ptr_t'(ls_valid1) + ptr_t'(ls_valid2);
    cmt_n   = cmt_ptr
            + ptr_t'(load_commit_valid)
            + ptr_t'(store_commit_valid);
    if (squash) begin
      tail_n = cmt_n;
    end else if (alloc_ok) begin
      tail_n = tail + alloc_n;
    end else begin
      tail_n = tail;
    end
    drop_n = tail - cmt_n;
  end

  // Entries between the new commit point and tail die on squash.
  always_comb begin
    discard = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = {1'b0, idx_t'(i) - cmt_n[IW-1:0]};
      discard[i] = off < drop_n;
    end
  end

  // Head leaves the queue on store handshake or load response.
  always_comb begin
    retire = 1'b0;
    unique case (state)
      REQ:       retire = mem.mem_req_ready && req_we_q;
      WAIT_RESP: retire = mem.mem_resp_valid;
      default:   retire = 1'b0;
    endcase
  end

  // Queue pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      cmt_ptr <= '0;
      tail    <= '0;
    end else begin
      head    <= head + ptr_t'(retire);
      cmt_ptr <= cmt_n;
      tail    <= tail_n;
    end
  end

  // Per-entry payload; always rewritten before it is trusted.
  always_ff @(posedge clk) begin
    if (alloc_ok && ls_valid1) begin
      ent_type[ls_entry1] <= ls_type1;
    end
    if (alloc_ok && ls_valid2) begin
      ent_type[ls_entry2] <= ls_type2;
    end
    if (addr_valid) begin
      ent_addr[addr_entry] <= addr;
      ent_data[addr_entry] <= store_data;
    end
  end

  // Per-entry flags and the misalignment flush strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_rdy    <= '0;
      committed   <= '0;
      flush_valid <= 1'b0;
      flush_entry <= '0;
    end else begin
      flush_valid <= addr_valid && aw_mis;
      if (addr_valid && aw_mis) begin
        flush_entry <= addr_entry;
      end
      if (alloc_ok && ls_valid1) begin
        addr_rdy[ls_entry1]  <= 1'b0;
        committed[ls_entry1] <= 1'b0;
      end
      if (alloc_ok && ls_valid2) begin
        addr_rdy[ls_entry2]  <= 1'b0;
        committed[ls_entry2] <= 1'b0;
      end
      if (addr_valid) begin
        addr_rdy[addr_entry] <= !aw_mis;
      end
      if (store_commit_valid) begin
        committed[store_commit_entry] <= 1'b1;
      end
      if (load_commit_valid) begin
        committed[load_commit_entry] <= 1'b1;
      end
      if (retire) begin
        addr_rdy[hidx]  <= 1'b0;
        committed[hidx] <= 1'b0;
      end
      if (squash) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (discard[i]) begin
            addr_rdy[i]  <= 1'b0;
            committed[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Memory FSM: one outstanding request, in program order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      req_valid_q     <= 1'b0;
      req_we_q        <= 1'b0;
      req_size_q      <= '0;
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      load_data       <= '0;
      load_data_valid <= 1'b0;
      load_data_entry <= '0;
    end else begin
      load_data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (head_ready) begin
            state       <= REQ;
            req_valid_q <= 1'b1;
            req_we_q    <= h_type[2];
            req_size_q  <= h_type[1:0];
            req_addr_q  <= ent_addr[hidx];
            req_wdata_q <= ent_data[hidx];
          end
        end
        REQ: begin
          if (mem.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= req_we_q ? IDLE : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem.mem_resp_valid) begin
            load_data       <= zext(req_size_q,
                                    mem.mem_resp_rdata);
            load_data_valid <= 1'b1;
            load_data_entry <= hidx;
            state           <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
